// File: rtl/dcache_pkg.sv
// Shared types, geometry and address/line helpers for the L1 data cache.
package dcache_pkg;

  localparam int SETS   = 32;
  localparam int IDX_W  = 5;
  localparam int OFF_W  = 5;
  localparam int TAG_W  = 32 - IDX_W - OFF_W;
  localparam int LINE_W = 256;
  localparam int WSEL_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_ALLOCATE  = 2'd2
  } state_e;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] addr);
    return addr[31:OFF_W+IDX_W];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] addr);
    return addr[OFF_W+IDX_W-1:OFF_W];
  endfunction

  function automatic logic [WSEL_W-1:0] addr_word(input logic [31:0] addr);
    return addr[OFF_W-1:2];
  endfunction

  // Byte address of the line holding addr (offset bits cleared).
  function automatic logic [31:0] line_base(input logic [31:0] addr);
    return addr & 32'hFFFF_FFE0;
  endfunction

  function automatic logic [31:0] line_word(input logic [LINE_W-1:0] line,
                                            input logic [WSEL_W-1:0] w);
    return line[{w, 5'b00000} +: 32];
  endfunction

  function automatic logic [LINE_W-1:0] line_merge(input logic [LINE_W-1:0] line,
                                                   input logic [WSEL_W-1:0] w,
                                                   input logic [31:0]       data);
    logic [LINE_W-1:0] m;
    m = line;
    m[{w, 5'b00000} +: 32] = data;
    return m;
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage: asynchronous read of one set, synchronous write.
module dcache_sram
  import dcache_pkg::*;
(
  input  logic              clk_i,
  input  logic              clr_valid_all_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic              we_i,
  input  logic [TAG_W-1:0]  wtag_i,
  input  logic [LINE_W-1:0] wline_i,
  input  logic              set_dirty_i,
  output logic              rd_valid_o,
  output logic              rd_dirty_o,
  output logic [TAG_W-1:0]  rd_tag_o,
  output logic [LINE_W-1:0] rd_line_o
);

  logic [SETS-1:0]   valid_q;
  logic [SETS-1:0]   dirty_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [LINE_W-1:0] data_q [SETS];

  // Status bits: cleared together on reset, updated on every line write.
  always_ff @(posedge clk_i) begin
    if (clr_valid_all_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (we_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= set_dirty_i;
    end
  end

  // Tag and data arrays are never cleared; valid gates their use.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_q[idx_i]  <= wtag_i;
      data_q[idx_i] <= wline_i;
    end
  end

  assign rd_valid_o = valid_q[idx_i];
  assign rd_dirty_o = dirty_q[idx_i];
  assign rd_tag_o   = tag_q[idx_i];
  assign rd_line_o  = data_q[idx_i];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate L1 D-cache controller. Hits finish
// in the MEM cycle; misses stall the pipeline through write-back and refill.
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [31:0]       cpu_wdata_i,
  output logic [31:0]       cpu_rdata_o,
  output logic              cpu_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic [LINE_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i
);

  state_e              state_q;
  logic                mem_req_q;
  logic                mem_we_q;

  logic [TAG_W-1:0]    req_tag_s;
  logic [IDX_W-1:0]    req_idx_s;
  logic [WSEL_W-1:0]   req_word_s;
  logic                rd_valid_s;
  logic                rd_dirty_s;
  logic [TAG_W-1:0]    rd_tag_s;
  logic [LINE_W-1:0]   rd_line_s;
  logic                hit_s;
  logic                miss_s;
  logic                store_hit_s;
  logic                refill_s;
  logic                sram_we_s;
  logic                sram_set_dirty_s;
  logic [LINE_W-1:0]   sram_wline_s;

  assign req_tag_s  = addr_tag(cpu_addr_i);
  assign req_idx_s  = addr_idx(cpu_addr_i);
  assign req_word_s = addr_word(cpu_addr_i);

  dcache_sram u_sram (
    .clk_i           (clk_i),
    .clr_valid_all_i (rst_i),
    .idx_i           (req_idx_s),
    .we_i            (sram_we_s),
    .wtag_i          (req_tag_s),
    .wline_i         (sram_wline_s),
    .set_dirty_i     (sram_set_dirty_s),
    .rd_valid_o      (rd_valid_s),
    .rd_dirty_o      (rd_dirty_s),
    .rd_tag_o        (rd_tag_s),
    .rd_line_o       (rd_line_s)
  );

  // Hit/miss decision; only meaningful while the FSM is idle.
  always_comb begin
    hit_s  = 1'b0;
    miss_s = 1'b0;
    if (cpu_req_i && (state_q == ST_IDLE)) begin
      if (rd_valid_s && (rd_tag_s == req_tag_s)) begin
        hit_s = 1'b1;
      end else begin
        miss_s = 1'b1;
      end
    end else begin
      hit_s  = 1'b0;
      miss_s = 1'b0;
    end
  end

  assign store_hit_s = hit_s & cpu_we_i;
  assign refill_s    = (state_q == ST_ALLOCATE) & mem_ack_i;

  // CPU-facing results: load word on a hit, stall on a miss or while busy.
  always_comb begin
    cpu_rdata_o = 32'h0000_0000;
    if (hit_s && !cpu_we_i) begin
      cpu_rdata_o = line_word(rd_line_s, req_word_s);
    end else begin
      cpu_rdata_o = 32'h0000_0000;
    end
    cpu_stall_o = miss_s | (state_q != ST_IDLE);
  end

  // Array write port: refill installs a clean line, a store hit merges one word.
  always_comb begin
    sram_we_s        = (store_hit_s | refill_s) & ~rst_i;
    sram_wline_s     = rd_line_s;
    sram_set_dirty_s = 1'b0;
    if (refill_s) begin
      sram_wline_s     = mem_rdata_i;
      sram_set_dirty_s = 1'b0;
    end else begin
      sram_wline_s     = line_merge(rd_line_s, req_word_s, cpu_wdata_i);
      sram_set_dirty_s = 1'b1;
    end
  end

  // Memory address: victim line during write-back, requested line otherwise.
  always_comb begin
    mem_addr_o = line_base(cpu_addr_i);
    case (state_q)
      ST_WRITEBACK: mem_addr_o = {rd_tag_s, req_idx_s, {OFF_W{1'b0}}};
      default:      mem_addr_o = line_base(cpu_addr_i);
    endcase
  end

  assign mem_wdata_o = rd_line_s;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;

  // Miss FSM with registered memory request/direction; reset abandons any
  // in-flight transaction.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (miss_s) begin
            mem_req_q <= 1'b1;
            if (rd_valid_s && rd_dirty_s) begin
              state_q  <= ST_WRITEBACK;
              mem_we_q <= 1'b1;
            end else begin
              state_q  <= ST_ALLOCATE;
              mem_we_q <= 1'b0;
            end
          end else begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
          end
        end
        ST_WRITEBACK: begin
          if (mem_ack_i) begin
            state_q  <= ST_ALLOCATE;
            mem_we_q <= 1'b0;
          end
        end
        ST_ALLOCATE: begin
          if (mem_ack_i) begin
            state_q   <= ST_IDLE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a line-wide memory that acknowledges
// ten cycles after it accepts a request.
module tb_dcache_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         cpu_req_i;
  logic         cpu_we_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_wdata_i;
  logic [31:0]  cpu_rdata_o;
  logic         cpu_stall_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_wdata_o;
  logic [255:0] mem_rdata_i;
  logic         mem_ack_i;

  int checks = 0;
  int errors = 0;

  // Memory model state
  logic [255:0] mem [logic [31:0]];
  bit           m_busy = 1'b0;
  int           m_cnt  = 0;
  logic         m_we;
  logic [31:0]  m_addr;
  logic [255:0] m_wdata;

  // Log of accepted memory transactions
  logic         log_we    [$];
  logic [31:0]  log_addr  [$];
  logic [255:0] log_wdata [$];

  always #5 clk_i = ~clk_i;

  dcache_ctrl dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cpu_req_i   (cpu_req_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_wdata_i (cpu_wdata_i),
    .cpu_rdata_o (cpu_rdata_o),
    .cpu_stall_o (cpu_stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i)
  );

  // Untouched memory: word k of line at base b reads 0xD000_0000 + b + 4k.
  function automatic logic [255:0] mem_line(input logic [31:0] base);
    logic [255:0] l;
    if (mem.exists(base)) begin
      l = mem[base];
    end else begin
      for (int k = 0; k < 8; k++) l[k*32 +: 32] = 32'hD000_0000 + base + 32'(k * 4);
    end
    return l;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: memory model looks at this cycle, then the edge, then new ack.
  // A request is accepted when the memory is idle; a write-back ack cycle may
  // accept the fetch that follows on the still-high request.
  task automatic tick();
    logic         nxt_ack;
    logic [255:0] nxt_data;
    nxt_ack  = 1'b0;
    nxt_data = '0;
    if (m_busy) begin
      if (m_cnt == 1) begin
        m_we    = mem_we_o;
        m_addr  = mem_addr_o;
        m_wdata = mem_wdata_o;
        log_we.push_back(mem_we_o);
        log_addr.push_back(mem_addr_o);
        log_wdata.push_back(mem_wdata_o);
      end
      if (m_cnt == 9) begin
        nxt_ack = 1'b1;
        m_busy  = 1'b0;
        if (m_we) mem[m_addr] = m_wdata;
        else      nxt_data = mem_line(m_addr);
      end else begin
        m_cnt++;
      end
    end else if (mem_req_o === 1'b1 && !(mem_ack_i && !mem_we_o)) begin
      m_busy = 1'b1;
      m_cnt  = 1;
    end
    @(posedge clk_i);
    #1;
    mem_ack_i   = nxt_ack;
    mem_rdata_i = nxt_data;
    #1;
  endtask

  task automatic idle();
    cpu_req_i = 1'b0;
    cpu_we_i  = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rst_i     = 1'b1;
    cpu_req_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;
    #1;
  endtask

  // Present one access, count stall cycles, check load data, let it commit.
  task automatic access(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input int exp_stall,
                        input int exp_reqs, input logic [31:0] exp_rdata);
    int n0;
    int n;
    cpu_req_i   = 1'b1;
    cpu_we_i    = we;
    cpu_addr_i  = addr;
    cpu_wdata_i = wdata;
    #1;
    n0 = log_addr.size();
    n  = 0;
    while (cpu_stall_o && n < 100) begin
      n++;
      tick();
    end
    chk({tag, " stall_cycles"}, 256'(n), 256'(exp_stall));
    if (!we) chk({tag, " rdata"}, 256'(cpu_rdata_o), 256'(exp_rdata));
    tick();
    chk({tag, " mem_reqs"}, 256'(log_addr.size() - n0), 256'(exp_reqs));
  endtask

  task automatic chk_log(input string tag, input int i, input logic we, input logic [31:0] addr);
    if (i < log_addr.size()) begin
      chk({tag, " we"}, 256'(log_we[i]), 256'(we));
      chk({tag, " addr"}, 256'(log_addr[i]), 256'(addr));
    end else begin
      chk({tag, " present"}, 256'(log_addr.size()), 256'(i + 1));
    end
  endtask

  initial begin
    int b;
    logic [255:0] wb;
    rst_i       = 1'b1;
    cpu_req_i   = 1'b0;
    cpu_we_i    = 1'b0;
    cpu_addr_i  = 32'h0;
    cpu_wdata_i = 32'h0;
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;

    do_reset();
    chk("reset stall", 256'(cpu_stall_o), 256'(0));
    chk("reset mem_req", 256'(mem_req_o), 256'(0));
    chk("reset mem_we", 256'(mem_we_o), 256'(0));
    chk("reset rdata", 256'(cpu_rdata_o), 256'(0));

    // Cold load
    b = log_addr.size();
    access("lw 0x0 cold", 1'b0, 32'h0, 32'h0, 12, 1, 32'hD000_0000);
    chk_log("lw 0x0 fetch", b, 1'b0, 32'h0);
    idle();

    // Cold store, store hit, back-to-back load hit
    do_reset();
    b = log_addr.size();
    access("sw 0x4 cold", 1'b1, 32'h4, 32'h0000_1234, 12, 1, 32'h0);
    chk_log("sw 0x4 fetch", b, 1'b0, 32'h0);
    access("sw 0x8 hit", 1'b1, 32'h8, 32'h0000_BEEF, 0, 0, 32'h0);
    access("lw 0x4 hit", 1'b0, 32'h4, 32'h0, 0, 0, 32'h0000_1234);

    // Dirty conflict on index 0
    b = log_addr.size();
    access("lw 0x400 dirty", 1'b0, 32'h400, 32'h0, 22, 2, 32'hD000_0400);
    chk_log("wb", b, 1'b1, 32'h0);
    chk_log("refill 0x400", b + 1, 1'b0, 32'h400);
    if (b < log_wdata.size()) begin
      wb = log_wdata[b];
      chk("wb word0", 256'(wb[31:0]), 256'(32'hD000_0000));
      chk("wb word1", 256'(wb[63:32]), 256'(32'h0000_1234));
      chk("wb word2", 256'(wb[95:64]), 256'(32'h0000_BEEF));
    end else begin
      chk("wb data present", 256'(log_wdata.size()), 256'(b + 1));
    end
    idle();

    // Clean conflict on index 1
    access("lw 0x20 cold", 1'b0, 32'h20, 32'h0, 12, 1, 32'hD000_0020);
    b = log_addr.size();
    access("lw 0x420 clean", 1'b0, 32'h420, 32'h0, 12, 1, 32'hD000_0420);
    chk_log("refill 0x420", b, 1'b0, 32'h420);
    idle();

    // Spurious ack while idle, then word-7 hit
    mem_ack_i = 1'b1;
    #1;
    tick();
    chk("spurious ack mem_req", 256'(mem_req_o), 256'(0));
    chk("spurious ack stall", 256'(cpu_stall_o), 256'(0));
    access("lw 0x41C word7", 1'b0, 32'h41C, 32'h0, 0, 0, 32'hD000_041C);
    idle();

    // Reset during ALLOCATE
    cpu_req_i  = 1'b1;
    cpu_we_i   = 1'b0;
    cpu_addr_i = 32'h800;
    #1;
    tick();
    tick();
    tick();
    chk("alloc mem_req", 256'(mem_req_o), 256'(1));
    chk("alloc mem_we", 256'(mem_we_o), 256'(0));
    rst_i     = 1'b1;
    cpu_req_i = 1'b0;
    tick();
    chk("mid-miss reset mem_req", 256'(mem_req_o), 256'(0));
    chk("mid-miss reset stall", 256'(cpu_stall_o), 256'(0));
    rst_i = 1'b0;
    repeat (12) tick();
    chk("late ack mem_req", 256'(mem_req_o), 256'(0));

    // Valid bits cleared: a line that hit before reset misses now
    access("lw 0x404 after reset", 1'b0, 32'h404, 32'h0, 12, 1, 32'hD000_0404);
    b = log_addr.size();
    access("lw 0x0 after reset", 1'b0, 32'h0, 32'h0, 12, 1, 32'hD000_0000);
    chk_log("refill 0x0", b, 1'b0, 32'h0);
    access("lw 0x4 written back", 1'b0, 32'h4, 32'h0, 0, 0, 32'h0000_1234);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
